// File: rtl/data_mem_stack_ctrl.sv
// Word-to-byte sequencer between the memory stage and a byte-wide data memory; owns the stack pointer.
// Optional stack overflow/underflow rejection is enabled by defining STACK_GUARD_EN.
module data_mem_stack_ctrl #(
  parameter int AW          = 10,
  parameter int STACK_BASE  = 1024,
  parameter int STACK_LIMIT = 768
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_data,
  output logic          resp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [AW:0]   sp
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DRAIN, S_RESP} state_t;

  localparam logic [2:0]  OP_LW   = 3'd0;
  localparam logic [2:0]  OP_SW   = 3'd1;
  localparam logic [2:0]  OP_PUSH = 3'd2;
  localparam logic [2:0]  OP_POP  = 3'd3;
  localparam logic [2:0]  OP_CALL = 3'd4;
  localparam logic [2:0]  OP_RET  = 3'd5;
  localparam logic [AW:0] SP_BASE  = (AW+1)'(STACK_BASE);
  localparam logic [31:0] ADDR_TOP = 32'((2**AW) - 3);

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic          is_rd_q;
  logic [31:0]   wdata_q;
  logic [23:0]   acc_q;
  logic [AW:0]   sp_q;
  logic          req_ready_q, resp_valid_q, resp_err_q, mem_en_q, mem_we_q;
  logic [31:0]   resp_data_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_wdata_q;

  logic [AW:0]   sp_m4_s, sp_p4_s, sp_d;
  logic [AW-1:0] ea_d;
  logic          err_s, rd_s, addr_bad_s;

  assign sp_m4_s    = sp_q - (AW+1)'(4);
  assign sp_p4_s    = sp_q + (AW+1)'(4);
  assign addr_bad_s = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_TOP);

`ifndef STACK_GUARD_EN
  logic unused_limit_s;
  assign unused_limit_s = ^(AW+1)'(STACK_LIMIT);
`endif

  // Request decode: effective address, next stack pointer and rejection.
  always_comb begin
    ea_d  = req_addr[AW-1:0];
    sp_d  = sp_q;
    err_s = 1'b0;
    rd_s  = 1'b0;
    case (req_op)
      OP_LW: begin
        rd_s  = 1'b1;
        err_s = addr_bad_s;
      end
      OP_SW: begin
        err_s = addr_bad_s;
      end
      OP_PUSH, OP_CALL: begin
        ea_d = sp_m4_s[AW-1:0];
`ifdef STACK_GUARD_EN
        if (sp_m4_s < (AW+1)'(STACK_LIMIT)) begin
          err_s = 1'b1;
        end else begin
          sp_d = sp_m4_s;
        end
`else
        sp_d = sp_m4_s;
`endif
      end
      OP_POP, OP_RET: begin
        rd_s = 1'b1;
        ea_d = sp_q[AW-1:0];
`ifdef STACK_GUARD_EN
        if (sp_q >= SP_BASE) begin
          err_s = 1'b1;
        end else begin
          sp_d = sp_p4_s;
        end
`else
        sp_d = sp_p4_s;
`endif
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
  end

  // Sequencer FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      is_rd_q      <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      acc_q        <= 24'h00_0000;
      sp_q         <= SP_BASE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (err_s) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= 32'h0000_0000;
            end else begin
              state_q     <= S_BEAT;
              cnt_q       <= 2'd0;
              is_rd_q     <= rd_s;
              wdata_q     <= req_wdata;
              sp_q        <= sp_d;
              mem_en_q    <= 1'b1;
              mem_we_q    <= ~rd_s;
              mem_addr_q  <= ea_d;
              mem_wdata_q <= req_wdata[7:0];
            end
          end
        end
        S_BEAT: begin
          // Read data lags its beat by one cycle, so bytes 0..2 land here and byte 3 in DRAIN.
          if (is_rd_q && (cnt_q != 2'd0)) begin
            acc_q <= {mem_rdata, acc_q[23:8]};
          end
          if (cnt_q == 2'd3) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (is_rd_q) begin
              state_q <= S_DRAIN;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= 32'h0000_0000;
            end
          end else begin
            cnt_q       <= cnt_q + 2'd1;
            mem_addr_q  <= mem_addr_q + AW'(1);
            mem_wdata_q <= wdata_q[15:8];
            wdata_q     <= {8'h00, wdata_q[31:8]};
          end
        end
        S_DRAIN: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= {mem_rdata, acc_q};
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_data_q  <= 32'h0000_0000;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          mem_en_q     <= 1'b0;
          mem_we_q     <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign sp         = sp_q;

endmodule

// File: tb/tb_data_mem_stack_ctrl.sv
// Scoreboard bench for data_mem_stack_ctrl with a byte-memory model; expected responses and
// memory beats are queued at issue time and checked by an independent monitor.
module tb_data_mem_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [10:0] sp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [31:0] data; logic err; } resp_t;
  typedef struct { int cyc; logic we; logic [9:0] addr; logic [7:0] data; } acc_t;
  resp_t rq[$];
  acc_t  aq[$];
  logic [7:0] mem [0:1023];

  data_mem_stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sp(sp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Monitor: compares every response and every memory beat against the queues.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp cyc=%0d data=%h err=%b", cyc, resp_data, resp_err);
      end else begin
        resp_t e;
        e = rq.pop_front();
        if (cyc != e.cyc || resp_data != e.data || resp_err != e.err) begin
          errors++;
          $display("FAIL resp got cyc=%0d data=%h err=%b exp cyc=%0d data=%h err=%b",
                   cyc, resp_data, resp_err, e.cyc, e.data, e.err);
        end
      end
    end
    if (rst_n && mem_en) begin
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem cyc=%0d we=%b addr=%h", cyc, mem_we, mem_addr);
      end else begin
        acc_t a;
        a = aq.pop_front();
        if (cyc != a.cyc || mem_we != a.we || mem_addr != a.addr || (a.we && mem_wdata != a.data)) begin
          errors++;
          $display("FAIL mem_beat got cyc=%0d we=%b addr=%h data=%h exp cyc=%0d we=%b addr=%h data=%h",
                   cyc, mem_we, mem_addr, mem_wdata, a.cyc, a.we, a.addr, a.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got req_ready=0 exp 1");
    end
  endtask

  // Issue one request; queue the expected beats and response.
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [9:0] ea, input logic [31:0] exp_data, input logic exp_err,
                      input bit no_resp = 1'b0);
    bit wr;
    resp_t r;
    wait_ready();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    wr = (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        acc_t a;
        a.cyc = cyc + 1 + i; a.we = wr; a.addr = ea + 10'(i);
        a.data = wd[8*i +: 8];
        if (!(no_resp && i >= 2)) aq.push_back(a);
      end
    end
    r.cyc  = cyc + (exp_err ? 1 : (wr ? 5 : 6));
    r.data = exp_data; r.err = exp_err;
    if (!no_resp) rq.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || aq.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (rq.size() != 0 || aq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got rq=%0d aq=%0d exp 0 0", rq.size(), aq.size());
    end
    wait_ready();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp", 32'(sp), 32'd1024);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    send(3'd1, 32'h10, 32'hA1B2_C3D4, 10'h010, 32'h0, 1'b0); drain();
    send(3'd0, 32'h10, 32'h0, 10'h010, 32'hA1B2_C3D4, 1'b0); drain();
    send(3'd2, 32'h0, 32'h1111_1111, 10'd1020, 32'h0, 1'b0); drain();
    chk("sp_push", 32'(sp), 32'd1020);
    send(3'd4, 32'h0, 32'h0000_0040, 10'd1016, 32'h0, 1'b0); drain();
    chk("sp_call", 32'(sp), 32'd1016);
    send(3'd5, 32'h0, 32'h0, 10'd1016, 32'h0000_0040, 1'b0); drain();
    chk("sp_ret", 32'(sp), 32'd1020);
    send(3'd3, 32'h0, 32'h0, 10'd1020, 32'h1111_1111, 1'b0); drain();
    chk("sp_pop", 32'(sp), 32'd1024);
    send(3'd0, 32'h12, 32'h0, 10'h0, 32'h0, 1'b1); drain();
    send(3'd7, 32'h10, 32'h0, 10'h0, 32'h0, 1'b1); drain();
    send(3'd6, 32'h10, 32'h0, 10'h0, 32'h0, 1'b1); drain();
    send(3'd1, 32'h400, 32'hDEAD_BEEF, 10'h0, 32'h0, 1'b1); drain();
    send(3'd0, 32'h3FC, 32'h0, 10'h3FC, 32'h1111_1111, 1'b0); drain();
    chk("sp_after_err", 32'(sp), 32'd1024);

`ifdef STACK_GUARD_EN
    send(3'd3, 32'h0, 32'h0, 10'h0, 32'h0, 1'b1); drain();
    chk("sp_underflow", 32'(sp), 32'd1024);
    for (int k = 0; k < 64; k++) begin
      send(3'd2, 32'h0, 32'h0101_0101 * (k + 1), 10'(1024 - 4 * (k + 1)), 32'h0, 1'b0);
      drain();
    end
    chk("sp_full", 32'(sp), 32'd768);
    send(3'd2, 32'h0, 32'h5555_5555, 10'h0, 32'h0, 1'b1); drain();
    chk("sp_overflow", 32'(sp), 32'd768);
`else
    send(3'd3, 32'h0, 32'h0, 10'h000, 32'h0, 1'b0); drain();
    chk("sp_pop_wrap", 32'(sp), 32'd1028);
    send(3'd2, 32'h0, 32'h0, 10'h000, 32'h0, 1'b0); drain();
    chk("sp_push_back", 32'(sp), 32'd1024);
`endif

    // Reset during beat 2 of a store: only beats 0 and 1 reach memory.
    send(3'd1, 32'h30, 32'h5566_7788, 10'h030, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_sp", 32'(sp), 32'd1024);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_queue", 32'(aq.size()), 32'd0);
    send(3'd0, 32'h30, 32'h0, 10'h030, 32'h0000_7788, 1'b0); drain();
    chk("final_sp", 32'(sp), 32'd1024);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
